sc_stream_decoder: RTL and testbench
====================================

Name: sc_stream_decoder

Overview:
- Downstream stage of the stochastic-computing datapath: it consumes the single-bit stochastic stream `output_circuit` produced by the 8-bit-LFSR/comparator/logic circuit.
- Counts ones over one fixed evaluation window and returns the binary result through a valid/ready handshake.
- Drives a stream-enable to the upstream circuit so the LFSR runs only while a window is in progress.
- Discards a fixed number of warm-up bits, covering upstream pipeline latency, before counting.

Parameters:
- WIN_LEN, 255, number of stream bits counted per window (one full period of the 8-bit maximal LFSR); legal range 1..65535.
- SKIP, 1, number of stream cycles discarded after start before counting begins; legal range 0..15.
- CNT_W, 8, result width; must satisfy 2^CNT_W > WIN_LEN.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous and active-low; clears all state.
- start  input  1  single-cycle request to begin a window; honoured only in IDLE.
- abort  input  1  cancels a window in progress; returns to IDLE with no result.
- bit_in  input  1  stochastic stream bit from upstream `output_circuit`, one bit per cycle while stream_en=1.
- stream_en  output  1  high in WARM and COUNT; upstream LFSR advances only when high.
- busy  output  1  high in any state other than IDLE.
- result  output  CNT_W  number of ones seen in the window; stable while result_valid=1.
- result_valid  output  1  result available.
- result_ready  input  1  consumer accepts result when result_valid and result_ready are both high on a clock edge.

Behaviour:
- Reset (asynchronous, rst_n=0) gives:
  - state=IDLE;
  - stream_en=0, busy=0, result_valid=0, result=0;
  - all internal counters=0.
- States and transitions:
  - IDLE: start=1 moves to WARM, or to COUNT if SKIP=0. The window counter and ones accumulator clear on the same edge.
  - WARM: skip counter increments every cycle and bit_in is ignored. After SKIP cycles in WARM, move to COUNT.
  - COUNT: each cycle, accumulator += bit_in and window counter increments. The cycle with window counter = WIN_LEN-1 is the last counted bit. On that edge, result <= accumulator + bit_in and the state moves to HOLD.
  - HOLD: stream_en=0, result_valid=1, result held. On result_valid & result_ready, move to IDLE with result_valid=0; result keeps its last value.
- Latency: result_valid rises exactly SKIP + WIN_LEN cycles after the edge that sampled start. With defaults this is 256 cycles.
- stream_en is registered from next-state, so it is high in exactly the cycles whose bit_in is sampled or skipped.
- Arithmetic:
  - Accumulator is CNT_W bits, unsigned.
  - Overflow is impossible by the parameter constraint, so no saturation logic is needed.
  - Window and skip counters are sized to WIN_LEN and SKIP independently of CNT_W.
- Boundary conditions:
  - start while busy: ignored, with no effect on counters.
  - start in the same cycle as a HOLD handshake: ignored; a new start is required from IDLE.
  - abort in WARM or COUNT: next state IDLE, stream_en=0, counters cleared, result and result_valid unchanged (result_valid stays 0).
  - abort in HOLD: ignored; the result is still delivered.
  - abort and start together in IDLE: start wins.
  - result_ready held high permanently: result_valid is high for exactly one cycle.
  - result_ready low: HOLD persists indefinitely with result stable.
  - WIN_LEN=1: a single counted bit; result is 0 or 1.
- Tie-off: bit_in is treated as don't-care outside COUNT; X on bit_in outside COUNT must not propagate.

Decomposition:
- Shared package sc_pkg holds:
  - state enum {IDLE, WARM, COUNT, HOLD} (2-bit encoding);
  - default constants SC_LFSR_W=8, SC_WIN_LEN=255, SC_SKIP=1;
  - function clog2 for counter sizing.
- One natural sub-module, sc_ones_counter: a clearable, enabled CNT_W-bit accumulator that adds bit_in, used for the ones count.
- The FSM, skip counter and window counter remain in the top.

Test Plan:
- bit_in constant 1, defaults, start pulse → result_valid at cycle 256 after start with result=255; stream_en high for exactly 256 cycles.
- bit_in constant 0 → result=0; with WIN_LEN=16, SKIP=0 → result_valid 16 cycles after start.
- bit_in alternating 1,0 starting with 1 on the first counted cycle, WIN_LEN=255, SKIP=1 → result=128; the bit driven during the WARM cycle (set to 1) is not counted.
- Abort asserted on counted cycle 100 → IDLE next cycle, busy=0, no result_valid. A following start with bit_in=1 gives result=255, proving the accumulator cleared.
- result_ready held low 10 cycles in HOLD → result stable, start pulses ignored, stream_en=0. Raise ready → one handshake, then IDLE.
- Asynchronous rst_n pulse mid-COUNT, between clock edges → all outputs 0 immediately. After release, start runs a full correct window.

Source files
------------

// File: rtl/sc_pkg.sv
// ---------------------------------------------------------------------------
// sc_pkg
// Shared definitions for the stochastic-computing stream decoder slice:
//   - sc_state_e : decoder FSM states (2-bit encoding)
//   - SC_*       : default datapath constants
//   - clog2      : counter sizing helper (never returns less than 1)
// ---------------------------------------------------------------------------
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WARM  = 2'd1,
        COUNT = 2'd2,
        HOLD  = 2'd3
    } sc_state_e;

    localparam int SC_LFSR_W  = 8;
    localparam int SC_WIN_LEN = 255;
    localparam int SC_SKIP    = 1;

    // Bits needed to hold values 0..value-1. A result of at least 1 keeps
    // zero-width vectors out of the design for degenerate parameters.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sc_stream_decoder_if.sv
// ---------------------------------------------------------------------------
// sc_stream_decoder_if
// Control, stream and result handshake signals of the stream decoder.
//   start, abort   : window control from the system
//   bit_in         : stochastic stream bit from upstream output_circuit
//   stream_en      : enables the upstream LFSR
//   busy           : decoder not idle
//   result         : ones count of the last window (CNT_W bits)
//   result_valid / result_ready : result handshake
// Modports: master = system side, slave = decoder side.
// ---------------------------------------------------------------------------
interface sc_stream_decoder_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic             bit_in;
    logic             stream_en;
    logic             busy;
    logic [CNT_W-1:0] result;
    logic             result_valid;
    logic             result_ready;

    modport master (
        output start, abort, bit_in, result_ready,
        input  stream_en, busy, result, result_valid
    );

    modport slave (
        input  start, abort, bit_in, result_ready,
        output stream_en, busy, result, result_valid
    );
endinterface

// File: rtl/sc_ones_counter.sv
// ---------------------------------------------------------------------------
// sc_ones_counter
// Clearable, enabled CNT_W-bit accumulator of single-bit inputs.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : add bit_in this cycle; bit_in is ignored while low
//   bit_in     : bit to accumulate
//   count      : running total
// ---------------------------------------------------------------------------
module sc_ones_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(bit_in);
        end
    end

endmodule

// File: rtl/sc_stream_decoder.sv
// ---------------------------------------------------------------------------
// sc_stream_decoder
// Counts ones of a stochastic bit stream over one window of WIN_LEN bits,
// after discarding SKIP warm-up bits, and returns the count via valid/ready.
//   clk, rst_n : clock, async active-low reset
//   bus        : sc_stream_decoder_if.slave (start/abort, bit_in, stream_en,
//                busy, result/result_valid/result_ready)
// Parameters: WIN_LEN (1..65535), SKIP (0..15), CNT_W with 2**CNT_W > WIN_LEN.
// ---------------------------------------------------------------------------
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int WIN_LEN = SC_WIN_LEN,
    parameter int SKIP    = SC_SKIP,
    parameter int CNT_W   = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    sc_stream_decoder_if.slave    bus
);

    localparam int WIN_W = clog2(WIN_LEN + 1);
    localparam int SKIP_W = clog2(SKIP + 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN - 1);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);

    sc_state_e         state, state_nx;
    logic [SKIP_W-1:0] skip_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [CNT_W-1:0]  acc_count;
    logic              acc_clr;
    logic              acc_en;
    logic              load_result;
    logic              stream_en_q;
    logic [CNT_W-1:0]  result_q;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nx    = state;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
        load_result = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_clr = 1'b1;
                    if (SKIP == 0) state_nx = COUNT;
                    else           state_nx = WARM;
                end
            end
            WARM: begin
                if (bus.abort) begin
                    state_nx = IDLE;
                    acc_clr  = 1'b1;
                end else if (skip_cnt == SKIP_LAST) begin
                    state_nx = COUNT;
                end
            end
            COUNT: begin
                if (bus.abort) begin
                    state_nx = IDLE;
                    acc_clr  = 1'b1;
                end else begin
                    acc_en = 1'b1;
                    if (win_cnt == WIN_LAST) begin
                        state_nx    = HOLD;
                        load_result = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.result_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: the result register is reset along with the control state so the
    // output reads 0 after reset rather than stale or unknown data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            skip_cnt    <= '0;
            win_cnt     <= '0;
            stream_en_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state       <= state_nx;
            // Counters run only while staying in their state; any entry,
            // exit or abort leaves them at zero for the next window.
            skip_cnt    <= (state == WARM && state_nx == WARM)
                           ? skip_cnt + SKIP_W'(1) : '0;
            win_cnt     <= (state == COUNT && state_nx == COUNT)
                           ? win_cnt + WIN_W'(1) : '0;
            // Registered from next state: high exactly in the cycles whose
            // bit_in is skipped or counted.
            stream_en_q <= (state_nx == WARM) || (state_nx == COUNT);
            if (load_result) begin
                result_q <= acc_count + CNT_W'(bus.bit_in);
            end
        end
    end

    sc_ones_counter #(
        .CNT_W (CNT_W)
    ) u_ones (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc_clr),
        .en     (acc_en),
        .bit_in (bus.bit_in),
        .count  (acc_count)
    );

    assign bus.stream_en    = stream_en_q;
    assign bus.busy         = (state != IDLE);
    assign bus.result_valid = (state == HOLD);
    assign bus.result       = result_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_sc_stream_decoder
// Three decoder instances: defaults (255/1), WIN_LEN=16/SKIP=0, WIN_LEN=1.
// Expected counts come from the window rule: bits presented on edges
// SKIP+1 .. SKIP+WIN_LEN after the start edge are summed.
// ---------------------------------------------------------------------------
module tb_sc_stream_decoder;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    int win_p[3]  = '{255, 16, 1};
    int skip_p[3] = '{1, 0, 0};

    sc_stream_decoder_if #(.CNT_W(8)) if_a ();
    sc_stream_decoder_if #(.CNT_W(5)) if_b ();
    sc_stream_decoder_if #(.CNT_W(1)) if_c ();

    sc_stream_decoder #(.WIN_LEN(255), .SKIP(1), .CNT_W(8)) u_a (
        .clk (clk), .rst_n (rst_n), .bus (if_a)
    );
    sc_stream_decoder #(.WIN_LEN(16), .SKIP(0), .CNT_W(5)) u_b (
        .clk (clk), .rst_n (rst_n), .bus (if_b)
    );
    sc_stream_decoder #(.WIN_LEN(1), .SKIP(0), .CNT_W(1)) u_c (
        .clk (clk), .rst_n (rst_n), .bus (if_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic st, input logic ab,
                          input logic b, input logic rdy);
        case (sel)
            0: begin if_a.start = st; if_a.abort = ab; if_a.bit_in = b; if_a.result_ready = rdy; end
            1: begin if_b.start = st; if_b.abort = ab; if_b.bit_in = b; if_b.result_ready = rdy; end
            default: begin if_c.start = st; if_c.abort = ab; if_c.bit_in = b; if_c.result_ready = rdy; end
        endcase
    endtask

    task automatic get_out(input int sel, output logic en, output logic bsy,
                           output logic vld, output logic [7:0] res);
        res = '0;
        case (sel)
            0: begin en = if_a.stream_en; bsy = if_a.busy; vld = if_a.result_valid; res = if_a.result; end
            1: begin en = if_b.stream_en; bsy = if_b.busy; vld = if_b.result_valid; res[4:0] = if_b.result; end
            default: begin en = if_c.stream_en; bsy = if_c.busy; vld = if_c.result_valid; res[0] = if_c.result; end
        endcase
    endtask

    // Bit presented for edge j after start (edge 0 samples start).
    // 0: all ones  1: all zeros  2: warm bits 1, counted bits 1,0,1,0...
    // 3: random counted bits, X everywhere else (must not propagate)
    function automatic logic pick_bit(input int pattern, input int j,
                                      input int skip, input int win);
        bit counted;
        counted = (j > skip) && (j <= skip + win);
        case (pattern)
            0: return 1'b1;
            1: return 1'b0;
            2: begin
                if (j >= 1 && j <= skip) return 1'b1;
                if (!counted) return 1'b0;
                return ((j - skip - 1) % 2 == 0) ? 1'b1 : 1'b0;
            end
            default: return counted ? 1'($urandom % 2) : 1'bx;
        endcase
    endfunction

    // Pulses start, streams the pattern, stops at the first edge after which
    // result_valid is high (or when the cycle budget runs out).
    task automatic run_window(input int sel, input int pattern, input int extra_start_j,
                              input logic rdy, output int exp_ones, output int valid_j,
                              output int en_cnt, output logic [7:0] res_v);
        logic b, en, bsy, vld;
        logic [7:0] res;
        int lat;
        lat      = skip_p[sel] + win_p[sel];
        exp_ones = 0;
        valid_j  = -1;
        en_cnt   = 0;
        res_v    = 'x;
        for (int j = 0; j <= lat + 4; j++) begin
            b = pick_bit(pattern, j, skip_p[sel], win_p[sel]);
            set_in(sel, (j == 0) || (j == extra_start_j), 1'b0, b, rdy);
            if (j > skip_p[sel] && j <= lat && b === 1'b1) exp_ones++;
            get_out(sel, en, bsy, vld, res);
            if (en === 1'b1) en_cnt++;
            @(posedge clk); #1;
            get_out(sel, en, bsy, vld, res);
            if (vld === 1'b1) begin
                valid_j = j;
                res_v   = res;
                break;
            end
        end
        set_in(sel, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        int exp_ones, valid_j, en_cnt;
        logic [7:0] res_v, res;
        logic en, bsy, vld;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int s = 0; s < 3; s++) set_in(s, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        #12;
        get_out(0, en, bsy, vld, res);
        check("rst_stream_en", en, 0);
        check("rst_busy", bsy, 0);
        check("rst_valid", vld, 0);
        check("rst_result", res, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All ones, ready held high: valid for exactly one cycle
        run_window(0, 0, -1, 1'b1, exp_ones, valid_j, en_cnt, res_v);
        check("ones_latency", valid_j, 256);
        check("ones_result", res_v, exp_ones);
        check("ones_stream_en_cycles", en_cnt, 256);
        @(posedge clk); #1;
        get_out(0, en, bsy, vld, res);
        check("ones_valid_one_cycle", vld, 0);
        check("ones_idle_after", bsy, 0);
        check("ones_result_kept", res, exp_ones);
        check("ones_stream_en_low", en, 0);

        // All zeros, with a start pulse while busy
        run_window(0, 1, 50, 1'b1, exp_ones, valid_j, en_cnt, res_v);
        check("zeros_latency", valid_j, 256);
        check("zeros_result", res_v, exp_ones);
        @(posedge clk); #1;

        // Alternating counted bits, warm bit set to 1
        run_window(0, 2, -1, 1'b1, exp_ones, valid_j, en_cnt, res_v);
        check("alt_latency", valid_j, 256);
        check("alt_result", res_v, exp_ones);
        @(posedge clk); #1;

        // Random bits, X outside window, ready low: HOLD persists
        run_window(0, 3, -1, 1'b0, exp_ones, valid_j, en_cnt, res_v);
        check("rand_latency", valid_j, 256);
        check("rand_result", res_v, exp_ones);
        for (int k = 0; k < 10; k++) begin
            set_in(0, (k % 2) == 0, (k % 2) == 1, 1'bx, 1'b0);
            @(posedge clk); #1;
            get_out(0, en, bsy, vld, res);
            check("hold_valid", vld, 1);
            check("hold_result", res, exp_ones);
            check("hold_stream_en", en, 0);
        end
        // Handshake together with start: start must be ignored
        set_in(0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b0);
        get_out(0, en, bsy, vld, res);
        check("handshake_valid_low", vld, 0);
        check("handshake_idle", bsy, 0);
        @(posedge clk); #1;
        get_out(0, en, bsy, vld, res);
        check("handshake_start_ignored", bsy, 0);

        // Abort in the middle of COUNT
        for (int j = 0; j <= 101; j++) begin
            set_in(0, j == 0, j == 101, 1'b1, 1'b1);
            @(posedge clk); #1;
        end
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b1);
        get_out(0, en, bsy, vld, res);
        check("abort_busy", bsy, 0);
        check("abort_stream_en", en, 0);
        check("abort_valid", vld, 0);
        repeat (3) @(posedge clk);
        #1;
        get_out(0, en, bsy, vld, res);
        check("abort_no_result", vld, 0);
        run_window(0, 0, -1, 1'b1, exp_ones, valid_j, en_cnt, res_v);
        check("post_abort_latency", valid_j, 256);
        check("post_abort_result", res_v, exp_ones);
        @(posedge clk); #1;

        // Asynchronous reset between edges mid-COUNT
        for (int j = 0; j < 60; j++) begin
            set_in(0, j == 0, 1'b0, 1'b1, 1'b0);
            @(posedge clk); #1;
        end
        set_in(0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        get_out(0, en, bsy, vld, res);
        check("arst_stream_en", en, 0);
        check("arst_busy", bsy, 0);
        check("arst_valid", vld, 0);
        check("arst_result", res, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_window(0, 3, -1, 1'b1, exp_ones, valid_j, en_cnt, res_v);
        check("arst_rerun_latency", valid_j, 256);
        check("arst_rerun_result", res_v, exp_ones);
        @(posedge clk); #1;

        // WIN_LEN=16, SKIP=0
        run_window(1, 1, -1, 1'b1, exp_ones, valid_j, en_cnt, res_v);
        check("b_zeros_latency", valid_j, 16);
        check("b_zeros_result", res_v, exp_ones);
        check("b_stream_en_cycles", en_cnt, 16);
        @(posedge clk); #1;
        run_window(1, 3, -1, 1'b1, exp_ones, valid_j, en_cnt, res_v);
        check("b_rand_latency", valid_j, 16);
        check("b_rand_result", res_v, exp_ones);
        @(posedge clk); #1;

        // WIN_LEN=1: single counted bit
        run_window(2, 0, -1, 1'b1, exp_ones, valid_j, en_cnt, res_v);
        check("c_ones_latency", valid_j, 1);
        check("c_ones_result", res_v, exp_ones);
        @(posedge clk); #1;
        run_window(2, 1, -1, 1'b1, exp_ones, valid_j, en_cnt, res_v);
        check("c_zeros_latency", valid_j, 1);
        check("c_zeros_result", res_v, exp_ones);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
